// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES-128 key schedule emitting round keys 0..10 over valid/ready.
// Define AES_KEY_STORE_EN to add an 11-entry round-key store with combinational read port.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // Forward AES S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[{~a, 3'b000} +: 8];
endmodule

module aes_key_expander #(
    parameter int KEY_W = 128,
    parameter int NR    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] cipher_key,
    input  logic             key_ready,
    output logic [KEY_W-1:0] round_key,
    output logic [3:0]       round_num,
    output logic             key_valid,
    output logic             busy,
    output logic             done
`ifdef AES_KEY_STORE_EN
    ,
    input  logic [3:0]       store_idx,
    output logic [KEY_W-1:0] store_key,
    output logic             store_full
`endif
);
    // state | meaning
    // IDLE  | waiting for start; done pulse clears here
    // EMIT  | round_key valid, advancing on each handshake
    typedef enum logic {IDLE, EMIT} state_t;

    state_t           state;
    logic [7:0]       rcon;
    logic [31:0]      w0, w1, w2, w3, rot, sub, t;
    logic [31:0]      n0, n1, n2, n3;
    logic [KEY_W-1:0] next_key;
    logic [7:0]       rcon_next;
    logic             handshake;

    assign w0  = round_key[127:96];
    assign w1  = round_key[95:64];
    assign w2  = round_key[63:32];
    assign w3  = round_key[31:0];
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (.a(rot[8*i +: 8]), .y(sub[8*i +: 8]));
    end

    assign t        = sub ^ {rcon, 24'h000000};
    assign n0       = w0 ^ t;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    assign handshake = (state == EMIT) && key_valid && key_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            round_key  <= '0;
            round_num  <= '0;
            key_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rcon       <= 8'h01;
`ifdef AES_KEY_STORE_EN
            store_full <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= EMIT;
                        round_key  <= cipher_key;
                        round_num  <= '0;
                        key_valid  <= 1'b1;
                        busy       <= 1'b1;
                        rcon       <= 8'h01;
`ifdef AES_KEY_STORE_EN
                        store_full <= 1'b0;
`endif
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        if (round_num == 4'(NR)) begin
                            state      <= IDLE;
                            key_valid  <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
`ifdef AES_KEY_STORE_EN
                            store_full <= 1'b1;
`endif
                        end else begin
                            round_key <= next_key;
                            round_num <= round_num + 4'd1;
                            rcon      <= rcon_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AES_KEY_STORE_EN
    logic [KEY_W-1:0] store_mem [0:NR];

    always_ff @(posedge clk) begin
        if (handshake) store_mem[round_num] <= round_key;
    end

    assign store_key = (store_idx <= 4'(NR)) ? store_mem[store_idx] : '0;
`endif
endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander: FIPS-197 key schedule vectors plus handshake corner cases.
module tb_aes_key_expander;
    logic         clk = 1'b0;
    logic         rst, start, key_ready;
    logic [127:0] cipher_key;
    logic [127:0] round_key;
    logic [3:0]   round_num;
    logic         key_valid, busy, done;
`ifdef AES_KEY_STORE_EN
    logic [3:0]   store_idx;
    logic [127:0] store_key;
    logic         store_full;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    typedef struct {
        logic [3:0]   num;
        logic [127:0] key;
    } vec_t;
    vec_t vec [11];

    aes_key_expander dut (
        .clk(clk), .rst(rst), .start(start), .cipher_key(cipher_key),
        .key_ready(key_ready), .round_key(round_key), .round_num(round_num),
        .key_valid(key_valid), .busy(busy), .done(done)
`ifdef AES_KEY_STORE_EN
        , .store_idx(store_idx), .store_key(store_key), .store_full(store_full)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic start_run(input logic [127:0] k);
        start      = 1'b1;
        cipher_key = k;
        step();
        start = 1'b0;
    endtask

    // Stream K1 keys from round lo..10 with ready held high, checking each one.
    task automatic stream_k1(input string tag, input int lo);
        key_ready = 1'b1;
        for (int i = lo; i <= 10; i++) begin
            check({tag, "_key"}, round_key, vec[i].key);
            check({tag, "_num"}, 128'(round_num), 128'(vec[i].num));
            check({tag, "_valid"}, 128'(key_valid), 128'(1));
            step();
        end
    endtask

    initial begin
        vec[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vec[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vec[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        vec[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        vec[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        vec[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        vec[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        vec[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        vec[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        vec[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        vec[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

        rst = 1'b1; start = 1'b0; key_ready = 1'b0; cipher_key = '0;
`ifdef AES_KEY_STORE_EN
        store_idx = 4'd0;
`endif
        repeat (2) step();
        rst = 1'b0;
        check("rst_key", round_key, '0);
        check("rst_num", 128'(round_num), '0);
        check("rst_valid", 128'(key_valid), '0);
        check("rst_busy", 128'(busy), '0);
        check("rst_done", 128'(done), '0);

        // Full run, ready held high: one key per cycle.
        start_run(K1);
        check("s1_busy", 128'(busy), 128'(1));
        stream_k1("s1", 0);
        check("s1_done", 128'(done), 128'(1));
        check("s1_busy_end", 128'(busy), '0);
        check("s1_valid_end", 128'(key_valid), '0);
        check("s1_hold_key", round_key, vec[10].key);
        check("s1_hold_num", 128'(round_num), 128'(10));
`ifdef AES_KEY_STORE_EN
        check("store_full", 128'(store_full), 128'(1));
        store_idx = 4'd1;
        #1 check("store_idx1", store_key, vec[1].key);
        store_idx = 4'd10;
        #1 check("store_idx10", store_key, vec[10].key);
        store_idx = 4'd15;
        #1 check("store_idx15", store_key, '0);
`endif
        step();
        check("s1_done_clear", 128'(done), '0);

        // Ready toggling: keys must hold while ready is low.
        begin
            int idx = 0;
            int cyc = 0;
            start_run(K1);
            while (!done && cyc < 100) begin
                key_ready = (cyc % 2 == 0);
                check("s2_key", round_key, vec[idx].key);
                check("s2_num", 128'(round_num), 128'(vec[idx].num));
                step();
                if (key_ready && idx < 10) idx++;
                cyc++;
            end
            check("s2_cycles", 128'(cyc), 128'(21));
            check("s2_done", 128'(done), 128'(1));
        end
        key_ready = 1'b1;
        step();

        // start mid-run (round 4) is ignored.
        start_run(K1);
        stream_k1("s3a", 0);
        check("s3_done_first", 128'(done), 128'(1));
        step();
        start_run(K1);
        for (int i = 0; i < 4; i++) step();
        check("s3_at4", 128'(round_num), 128'(4));
        start = 1'b1; cipher_key = K2;
        step();
        start = 1'b0;
        stream_k1("s3", 5);
        check("s3_done", 128'(done), 128'(1));
        step();

        // Reset at round 6, then a fresh run with the second key.
        start_run(K1);
        for (int i = 0; i < 6; i++) step();
        check("s4_at6", 128'(round_num), 128'(6));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("s4_rst_key", round_key, '0);
        check("s4_rst_num", 128'(round_num), '0);
        check("s4_rst_valid", 128'(key_valid), '0);
        check("s4_rst_busy", 128'(busy), '0);
        step();
        check("s4_idle_valid", 128'(key_valid), '0);
        start_run(K2);
        check("s4_r0", round_key, K2);
        for (int i = 0; i < 10; i++) step();
        check("s4_r10_num", 128'(round_num), 128'(10));
        check("s4_r10", round_key, K2_R10);
        step();
        check("s4_done", 128'(done), 128'(1));
        step();

        // start accepted in the done cycle.
        start_run(K1);
        stream_k1("s5", 0);
        check("s5_done", 128'(done), 128'(1));
        start_run(K2);
        check("s5_restart_valid", 128'(key_valid), 128'(1));
        check("s5_restart_key", round_key, K2);
        check("s5_restart_num", 128'(round_num), '0);
        check("s5_done_clear", 128'(done), '0);
        for (int i = 0; i < 10; i++) step();
        check("s5_r10", round_key, K2_R10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
Iterative AES-128 key schedule. Sits directly upstream of the round-key XOR stage and drives its 128-bit Key input.
- Loads a cipher key on start.
- Emits round keys 0..10 in order, one per accepted valid/ready handshake.
- One new round key is computed per cycle while the consumer keeps ready high.

Parameters:
KEY_W, 128, key and round-key width; only 128 is legal.
NR, 10, number of rounds; only 10 is legal; round_num runs 0..NR.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  load cipher_key and begin expansion; sampled only in IDLE
cipher_key  input  128  AES-128 cipher key, byte 0 in bits [127:120]
key_ready  input  1  downstream accepts round_key this cycle
round_key  output  128  current round key (Key input of the XOR stage)
round_num  output  4  index of round_key, 0..10
key_valid  output  1  round_key/round_num valid
busy  output  1  high from the cycle after start until the final handshake
done  output  1  one-cycle pulse after round-10 key accepted

Behaviour:
- Reset (rst=1 at clock edge, any state, including mid-expansion): state=IDLE; round_key=0, round_num=0, key_valid=0, busy=0, done=0, rcon=8'h01. No partial results survive.
- States: IDLE, EMIT.
- IDLE with start=1: next cycle state=EMIT, round_key=cipher_key, round_num=0, key_valid=1, busy=1. Latency start->first valid = 1 cycle.
- IDLE with start=0: outputs hold; done pulse from a prior run self-clears after 1 cycle.
- EMIT, key_valid=1, key_ready=0: round_key, round_num and key_valid held stable. No internal advance.
- EMIT, handshake with round_num<10: next cycle round_key=next schedule word set, round_num+1, key_valid stays 1. Back-to-back handshakes give one key per cycle.
- EMIT, handshake with round_num=10: next cycle state=IDLE, key_valid=0, busy=0, done=1 for exactly one cycle. round_key/round_num hold their last values.
- start while in EMIT is ignored. start in the same cycle as the done pulse (IDLE) is accepted.
- Next-key arithmetic, words w0..w3 = round_key[127:96]..[31:0]:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
  - RotWord rotates left one byte. SubWord applies the AES S-box bytewise (4 internal combinational S-box instances).
- rcon sequence 01,02,04,08,10,20,40,80,1b,36. Update is xtime: shift left 1, XOR 8'h1b on carry-out. rcon advances on each handshake and resets to 01 on start.
- All outputs are registered; no combinational path from key_ready to outputs.

Optional Feature:
Macro AES_KEY_STORE_EN.
- Defined:
  - Adds an 11x128 register file written with each round key as it is accepted by handshake.
  - Adds input store_idx[3:0], output store_key[127:0] (combinational read; idx>10 reads 0), and output store_full.
  - store_full goes 1 after the round-10 write. It clears on start or rst.
  - The decrypt path can then read keys in reverse order without re-expansion.
- Undefined: the store, the extra ports and the array are absent. Streaming behaviour is identical in both builds.

Test Plan:
- rst, start with cipher_key=2b7e151628aed2a6abf7158809cf4f3c, key_ready=1 held -> round 0 key = cipher key one cycle after start; round 1 = a0fafe1788542cb123a339392a6c7605 next cycle; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at cycle 11; done pulse at cycle 12; busy low at cycle 12.
- Same key, key_ready toggled 1/0 each cycle -> identical 11-key sequence; keys stable while ready=0; total 21 cycles from first valid to done.
- start asserted again at round_num=4 -> ignored; sequence continues unchanged through round 10.
- rst asserted at round_num=6 -> next cycle all outputs 0, state IDLE. A new start with key 000102030405060708090a0b0c0d0e0f gives round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Round 10 handshake and start in the cycle done=1 -> new run's round 0 valid on the following cycle.
- With AES_KEY_STORE_EN, after the first run -> store_full=1; store_idx=1 reads a0fafe17...2a6c7605; store_idx=15 reads 0.
